// File: rtl/fft_in_framer.sv
// rtl/fft_in_framer.sv - serial-to-16-lane framer feeding the FFT input, with frame/block indexing.
// Optional zero-pad flush of a partial frame is enabled by defining FRAMER_FLUSH_EN.
module fft_in_framer #(
    parameter int FRAMES_PER_BLK = 32
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               din_valid,
    input  logic signed [10:0] din_R,
    input  logic signed [10:0] din_Q,
`ifdef FRAMER_FLUSH_EN
    input  logic               din_flush,
`endif
    output logic               valid,
    output logic signed [10:0] d_in_R [0:15],
    output logic signed [10:0] d_in_Q [0:15],
    output logic [4:0]         frame_idx,
    output logic               blk_start
);

    localparam logic [4:0] LAST_FRAME = 5'(FRAMES_PER_BLK - 1);

    logic [3:0]         r_lane;
    logic [4:0]         r_frame_cnt;
    logic signed [10:0] r_cap_r [0:15];
    logic signed [10:0] r_cap_q [0:15];

    logic               w_emit;
    logic [3:0]         w_lane_next;
    logic signed [10:0] w_frame_r [0:15];
    logic signed [10:0] w_frame_q [0:15];

`ifdef FRAMER_FLUSH_EN
    // A flush only emits when there is at least one sample to carry, captured or arriving now.
    assign w_emit = (din_valid && (r_lane == 4'd15)) ||
                    (din_flush && (din_valid || (r_lane != 4'd0)));
`else
    assign w_emit = din_valid && (r_lane == 4'd15);
`endif

    always_comb begin
        w_lane_next = r_lane;
        if (w_emit) begin
            w_lane_next = 4'd0;
        end else if (din_valid) begin
            w_lane_next = r_lane + 4'd1;
        end
    end

    // Frame image as of this edge: captured lanes below the counter, the live sample
    // at the counter, zeros above (only reachable through a flush).
    always_comb begin
        for (int i = 0; i < 16; i++) begin
            w_frame_r[i] = 11'sd0;
            w_frame_q[i] = 11'sd0;
            if (din_valid && (r_lane == 4'(i))) begin
                w_frame_r[i] = din_R;
                w_frame_q[i] = din_Q;
            end else if (4'(i) < r_lane) begin
                w_frame_r[i] = r_cap_r[i];
                w_frame_q[i] = r_cap_q[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_lane      <= 4'd0;
            r_frame_cnt <= 5'd0;
            valid       <= 1'b0;
            blk_start   <= 1'b0;
            frame_idx   <= 5'd0;
            for (int i = 0; i < 16; i++) begin
                r_cap_r[i] <= 11'sd0;
                r_cap_q[i] <= 11'sd0;
                d_in_R[i]  <= 11'sd0;
                d_in_Q[i]  <= 11'sd0;
            end
        end else begin
            if (din_valid) begin
                r_cap_r[r_lane] <= din_R;
                r_cap_q[r_lane] <= din_Q;
            end
            r_lane    <= w_lane_next;
            valid     <= w_emit;
            blk_start <= w_emit && (r_frame_cnt == 5'd0);
            if (w_emit) begin
                for (int i = 0; i < 16; i++) begin
                    d_in_R[i] <= w_frame_r[i];
                    d_in_Q[i] <= w_frame_q[i];
                end
                frame_idx   <= r_frame_cnt;
                r_frame_cnt <= (r_frame_cnt == LAST_FRAME) ? 5'd0 : r_frame_cnt + 5'd1;
            end
        end
    end

endmodule

// File: tb/tb_fft_in_framer.sv
// tb/tb_fft_in_framer.sv - self-checking bench for fft_in_framer against a sample-queue reference model.
module tb_fft_in_framer;

    localparam int NFRAMES = 32;
`ifdef FRAMER_FLUSH_EN
    localparam bit FLUSH = 1'b1;
`else
    localparam bit FLUSH = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rstn = 1'b0;
    logic               din_valid = 1'b0;
    logic signed [10:0] din_R = '0;
    logic signed [10:0] din_Q = '0;
    logic               din_flush = 1'b0;
    logic               valid;
    logic signed [10:0] d_in_R [0:15];
    logic signed [10:0] d_in_Q [0:15];
    logic [4:0]         frame_idx;
    logic               blk_start;

    fft_in_framer #(.FRAMES_PER_BLK(NFRAMES)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .din_valid (din_valid),
        .din_R     (din_R),
        .din_Q     (din_Q),
`ifdef FRAMER_FLUSH_EN
        .din_flush (din_flush),
`endif
        .valid     (valid),
        .d_in_R    (d_in_R),
        .d_in_Q    (d_in_Q),
        .frame_idx (frame_idx),
        .blk_start (blk_start)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: pending samples in arrival order, last emitted frame, frames since reset.
    logic signed [10:0] q_r [$];
    logic signed [10:0] q_q [$];
    logic signed [10:0] m_r [16];
    logic signed [10:0] m_q [16];
    int                 m_idx;
    int                 n_emitted;
    bit                 exp_valid;
    bit                 exp_blk;

    function automatic bit frame_eq();
        for (int i = 0; i < 16; i++) begin
            if (d_in_R[i] !== m_r[i] || d_in_Q[i] !== m_q[i]) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic int first_bad_lane();
        for (int i = 0; i < 16; i++) begin
            if (d_in_R[i] !== m_r[i] || d_in_Q[i] !== m_q[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        q_r.delete();
        q_q.delete();
        for (int i = 0; i < 16; i++) begin
            m_r[i] = '0;
            m_q[i] = '0;
        end
        m_idx     = 0;
        n_emitted = 0;
        exp_valid = 1'b0;
        exp_blk   = 1'b0;
    endtask

    task automatic model_emit();
        while (q_r.size() < 16) begin
            q_r.push_back(11'sd0);
            q_q.push_back(11'sd0);
        end
        for (int i = 0; i < 16; i++) begin
            m_r[i] = q_r[i];
            m_q[i] = q_q[i];
        end
        q_r.delete();
        q_q.delete();
        m_idx     = n_emitted % NFRAMES;
        n_emitted = n_emitted + 1;
        exp_valid = 1'b1;
        exp_blk   = (m_idx == 0);
    endtask

    task automatic model_step(input bit v, input logic signed [10:0] r, input logic signed [10:0] q,
                              input bit fl);
        exp_valid = 1'b0;
        exp_blk   = 1'b0;
        if (v) begin
            q_r.push_back(r);
            q_q.push_back(q);
        end
        if (q_r.size() == 16) model_emit();
        else if (FLUSH && fl && q_r.size() != 0) model_emit();
    endtask

    task automatic check_outputs(input string tag);
        checks++;
        assert (valid === exp_valid) else begin
            errors++;
            $error("FAIL %s valid: got %0b want %0b", tag, valid, exp_valid);
        end
        checks++;
        assert (blk_start === exp_blk) else begin
            errors++;
            $error("FAIL %s blk_start: got %0b want %0b", tag, blk_start, exp_blk);
        end
        checks++;
        assert (frame_idx === 5'(m_idx)) else begin
            errors++;
            $error("FAIL %s frame_idx: got %0d want %0d", tag, frame_idx, m_idx);
        end
        checks++;
        assert (frame_eq()) else begin
            errors++;
            $error("FAIL %s lanes: lane %0d got R=%0d Q=%0d want R=%0d Q=%0d", tag,
                   first_bad_lane(), d_in_R[first_bad_lane()], d_in_Q[first_bad_lane()],
                   m_r[first_bad_lane()], m_q[first_bad_lane()]);
        end
    endtask

    // One clock of stimulus; called and returning at posedge+1.
    task automatic step(input string tag, input bit v, input logic signed [10:0] r,
                        input logic signed [10:0] q, input bit fl);
        din_valid = v;
        din_R     = r;
        din_Q     = q;
        din_flush = fl;
        @(posedge clk);
        #1;
        model_step(v, r, q, fl);
        check_outputs(tag);
    endtask

    task automatic apply_reset(input string tag);
        // Garbage on the inputs during reset must be ignored.
        din_valid = 1'b1;
        din_R     = 11'sd333;
        din_Q     = -11'sd333;
        din_flush = 1'b0;
        #2;
        rstn = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        check_outputs(tag);
        @(posedge clk);
        #1;
        check_outputs(tag);
        rstn = 1'b1;
    endtask

    logic signed [10:0] rr, rq;

    initial begin
        model_reset();
        apply_reset("reset");

        // Ramp R=k, Q=-k; released reset with din_valid high on the first edge.
        for (int k = 0; k < 16; k++) step("ramp", 1'b1, 11'(k), 11'(-k), 1'b0);
        for (int k = 0; k < 2; k++) step("ramp_hold", 1'b0, 11'sd5, 11'sd5, 1'b0);

        // Full-scale alternation.
        for (int k = 0; k < 16; k++)
            step("extreme", 1'b1, (k % 2) ? -11'sd1024 : 11'sd1023,
                 (k % 2) ? 11'sd1023 : -11'sd1024, 1'b0);

        // Valid toggling 1,0,1,0 with junk on idle cycles.
        for (int k = 0; k < 32; k++) begin
            rr = 11'($urandom);
            rq = 11'($urandom);
            step("toggle", (k % 2) == 0, rr, rq, 1'b0);
        end

        // Partial frame discarded by reset, then R=100+k.
        for (int k = 0; k < 7; k++) step("pre_reset", 1'b1, 11'sd500, 11'sd500, 1'b0);
        apply_reset("mid_reset");
        for (int k = 0; k < 16; k++) step("post_reset", 1'b1, 11'(100 + k), 11'($urandom), 1'b0);

        // Contiguous stream across a whole block and into the next.
        apply_reset("blk_reset");
        for (int k = 0; k < 528; k++) begin
            rr = 11'($urandom);
            rq = 11'($urandom);
            step("block", 1'b1, rr, rq, 1'b0);
        end

        // Random gaps of varying length; a partial frame stays pending.
        for (int k = 0; k < 300; k++) begin
            rr = 11'($urandom);
            rq = 11'($urandom);
            step("gaps", ($urandom_range(0, 99) < 40), rr, rq, 1'b0);
        end
        for (int k = 0; k < 20; k++) step("idle", 1'b0, 11'sd0, 11'sd0, 1'b0);

`ifdef FRAMER_FLUSH_EN
        apply_reset("flush_reset");
        for (int k = 0; k < 5; k++) step("flush5", 1'b1, 11'(-1024 + k), 11'($urandom), 1'b0);
        step("flush5_fl", 1'b0, 11'sd0, 11'sd0, 1'b1);
        for (int k = 0; k < 16; k++) step("after_flush", 1'b1, 11'($urandom), 11'($urandom), 1'b0);
        step("flush_idle", 1'b0, 11'sd0, 11'sd0, 1'b1);
        for (int k = 0; k < 3; k++) step("flush_v", 1'b1, 11'($urandom), 11'($urandom), 1'b0);
        step("flush_v_fl", 1'b1, 11'sd77, -11'sd77, 1'b1);
        for (int k = 0; k < 15; k++) step("flush15", 1'b1, 11'($urandom), 11'($urandom), 1'b0);
        step("flush15_fl", 1'b1, 11'sd42, -11'sd42, 1'b1);
        step("flush15_nx", 1'b0, 11'sd0, 11'sd0, 1'b1);
        step("flush_one", 1'b1, -11'sd9, 11'sd9, 1'b1);
        for (int k = 0; k < 200; k++) begin
            rr = 11'($urandom);
            rq = 11'($urandom);
            step("flush_rand", ($urandom_range(0, 99) < 60), rr, rq, ($urandom_range(0, 99) < 8));
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fft_in_framer.md
FFT_IN_FRAMER -- requirements
Module: fft_in_framer

Interface
REQ-001 Parameter FRAMES_PER_BLK, default 32, gives the number of 16-lane frames per FFT block (512 points).
REQ-002 clk  input  1  is the single clock; all state SHALL update on its rising edge.
REQ-003 rstn  input  1  is the reset; it SHALL be asynchronous and active-low.
REQ-004 din_valid  input  1  qualifies din_R and din_Q; one sample SHALL be accepted per cycle in which it is high.
REQ-005 din_R, din_Q  input  signed 11 each  carry the in-phase and quadrature sample.
REQ-006 din_flush  input  1  requests zero-padding of a partial frame; this port SHALL exist only under FRAMER_FLUSH_EN.
REQ-007 valid  output  1  is a one-cycle strobe marking a complete frame on d_in_R and d_in_Q.
REQ-008 d_in_R[0:15], d_in_Q[0:15]  output  signed 11 x 16 each  carry the parallel frame; lane 0 SHALL hold the oldest sample.
REQ-009 frame_idx  output  5  gives the index, within the block, of the frame currently presented.
REQ-010 blk_start  output  1  SHALL be high together with valid when frame_idx is 0.

Function
REQ-011 A lane counter (0..15) SHALL write each accepted sample into capture lane[lane counter], then increment.
- The counter SHALL wrap 15->0.
- It SHALL hold when din_valid is low.
REQ-012 On acceptance of the lane-15 sample, the full capture set SHALL be copied into the output registers at the same clock edge.
- valid SHALL be high in the following cycle only (latency 1 cycle from the 16th sample).
REQ-013 The output registers SHALL hold their value between valid strobes.
- The capture buffer SHALL accept lane 0 of the next frame in the same cycle as the copy, giving back-to-back operation with no stall or lost sample.
REQ-014 A frame counter (0..FRAMES_PER_BLK-1) SHALL advance on each emitted frame and wrap to 0 after FRAMES_PER_BLK-1.
- frame_idx SHALL reflect the counter value of the frame being presented.
REQ-015 Samples SHALL pass bit-exact, with no width change, saturation or reordering.
REQ-016 din_valid gaps of any length SHALL neither corrupt nor emit a partial frame.

Reset
REQ-017 When rstn is low:
- valid=0, blk_start=0, frame_idx=0, all d_in_R/d_in_Q lanes=0;
- lane counter and frame counter = 0;
- capture buffer cleared.
REQ-018 Reset asserted mid-frame SHALL discard captured samples.
- The first sample accepted after release SHALL land in lane 0 of frame 0.
REQ-019 din_valid in the cycle reset releases SHALL be accepted normally.

Configuration
REQ-020 With macro FRAMER_FLUSH_EN defined, din_flush high while the lane counter is nonzero SHALL:
- fill the remaining lanes with 0;
- emit the frame (valid next cycle);
- reset the lane counter to 0.
REQ-021 With FRAMER_FLUSH_EN defined, din_flush together with din_valid SHALL accept the sample first, then zero-pad from the next lane.
- If that sample fills lane 15, the frame SHALL be emitted normally with no extra frame.
REQ-022 With FRAMER_FLUSH_EN defined, din_flush while the lane counter is 0 and din_valid is low SHALL have no effect.
REQ-023 Without FRAMER_FLUSH_EN, the din_flush port and padding logic SHALL be absent.
- A partial frame SHALL remain pending until completed.

Verification
REQ-024 Drive 16 consecutive samples R=k, Q=-k (k=0..15) -> valid for one cycle, 1 cycle after k=15; d_in_R[k]=k, d_in_Q[k]=-k; frame_idx=0; blk_start=1.
REQ-025 Drive 512 contiguous samples -> 32 valid strobes exactly 16 cycles apart; frame_idx 0..31; blk_start only on the first; the 513th-528th samples give frame_idx=0 again.
REQ-026 Drive 16 samples with din_valid toggled 1,0,1,0 -> a single valid, 1 cycle after the 16th accepted sample, with lanes in acceptance order.
REQ-027 Drive 7 samples, pulse rstn low, then drive 16 samples R=100+k -> one frame with d_in_R[k]=100+k and frame_idx=0; the pre-reset data never appears.
REQ-028 (FRAMER_FLUSH_EN) Drive 5 samples R=-1024..-1020, then din_flush -> valid; lanes 0-4 = -1024..-1020; lanes 5-15 = 0; the next sample lands in lane 0 with frame_idx=1.
REQ-029 Extreme values: samples of +1023 and -1024 alternating for 16 samples -> output lanes bit-exact, with no sign corruption.
